// File: rtl/simplez_loader_pkg.sv
// Shared constants and state encoding for the Simplez serial program loader.
// Frame: HDR, LEN_H, LEN_L, {HI, LO} * n, CHK (8-bit sum of everything after HDR).
package simplez_loader_pkg;

  localparam int AW_DEFAULT = 9;
  localparam int DW_DEFAULT = 12;
  localparam int MAX_WORDS_DEFAULT = 504;

  localparam logic [7:0] HDR_DEFAULT = 8'h5A;
  localparam logic [7:0] ACK_OK  = 8'h4B;
  localparam logic [7:0] ACK_ERR = 8'h45;
  localparam logic [7:0] ACK_TMO = 8'h54;

  typedef enum logic [3:0] {
    ST_RUN,
    ST_IDLE,
    ST_LEN_H,
    ST_LEN_L,
    ST_DAT_H,
    ST_DAT_L,
    ST_WRITE,
    ST_CHK,
    ST_REPLY
  } state_t;

  // States in which the inter-byte gap is policed.
  function automatic logic in_frame(state_t s);
    return (s == ST_LEN_H) || (s == ST_LEN_L) || (s == ST_DAT_H) ||
           (s == ST_DAT_L) || (s == ST_WRITE) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/simplez_loader_if.sv
// Byte stream from uart_rx, reply path to uart_tx and the RAM write port.
interface simplez_loader_if #(
  parameter int AW = 9,
  parameter int DW = 12
);

  logic          rcv;
  logic [7:0]    rxdata;
  logic          tx_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          ram_cs;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;

  modport master (
    input  rcv, rxdata, tx_ready,
    output tx_start, tx_data, ram_cs, ram_rw, ram_addr, ram_din
  );

  modport slave (
    output rcv, rxdata, tx_ready,
    input  tx_start, tx_data, ram_cs, ram_rw, ram_addr, ram_din
  );

endinterface

// File: rtl/simplez_loader_timer.sv
// Divide-by-M counter: tick fires after M consecutive enabled cycles and the
// count clears whenever ena drops, so it measures an uninterrupted gap.
module simplez_loader_timer #(
  parameter int M = 2400000
) (
  input  logic clk,
  input  logic rstn,
  input  logic ena,
  output logic tick
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;

  logic [CW-1:0] count;

  assign tick = ena && (count == CW'(M - 1));

  always_ff @(posedge clk) begin
    if (!rstn || !ena) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/simplez_loader.sv
// Serial program loader: assembles 12-bit words from UART bytes, writes them to RAM
// from address 0, holds the CPU in reset meanwhile and answers K/E/T on uart_tx.
module simplez_loader
  import simplez_loader_pkg::*;
#(
  parameter int         AW        = AW_DEFAULT,
  parameter int         DW        = DW_DEFAULT,
  parameter int         MAX_WORDS = MAX_WORDS_DEFAULT,
  parameter int         TIMEOUT   = 2400000,
  parameter int         AUTORUN   = 1,
  parameter logic [7:0] HDR       = HDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rstn,
  simplez_loader_if.master   bus,
  output logic               cpu_rstn,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [AW-1:0] MAX_W = AW'(MAX_WORDS);
  localparam state_t        RESET_STATE = (AUTORUN != 0) ? ST_RUN : ST_IDLE;

  state_t        state;
  state_t        state_nxt;
  logic          pend;
  logic [7:0]    rx_byte;
  logic [AW-1:0] n;
  logic [AW-1:0] idx;
  logic [DW-1:0] word;
  logic [7:0]    sum;
  logic [7:0]    reply;
  logic [7:0]    reply_nxt;
  logic          take;
  logic          tmo;

  logic [AW-1:0] len_val;
  logic [AW-1:0] idx_inc;
  logic [7:0]    sum_add;
  logic          bad_len;

  assign len_val = {n[AW-1:8], rx_byte};
  assign idx_inc = idx + AW'(1);
  assign sum_add = sum + rx_byte;
  assign bad_len = (len_val == '0) || (len_val > MAX_W);

  simplez_loader_timer #(
    .M (TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .rstn (rstn),
    .ena  (in_frame(state) && !bus.rcv),
    .tick (tmo)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  // A pending byte is consumed only in states that expect one; WRITE and REPLY leave it waiting.
  always_comb begin
    state_nxt = state;
    reply_nxt = reply;
    take      = 1'b0;
    case (state)
      ST_RUN, ST_IDLE: begin
        if (pend) begin
          take = 1'b1;
          if (rx_byte == HDR) state_nxt = ST_LEN_H;
        end
      end
      ST_LEN_H: begin
        if (pend) begin
          take      = 1'b1;
          state_nxt = ST_LEN_L;
        end
      end
      ST_LEN_L: begin
        if (pend) begin
          take = 1'b1;
          if (bad_len) begin
            state_nxt = ST_REPLY;
            reply_nxt = ACK_ERR;
          end else begin
            state_nxt = ST_DAT_H;
          end
        end
      end
      ST_DAT_H: begin
        if (pend) begin
          take      = 1'b1;
          state_nxt = ST_DAT_L;
        end
      end
      ST_DAT_L: begin
        if (pend) begin
          take      = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_nxt = (idx_inc == n) ? ST_CHK : ST_DAT_H;
      end
      ST_CHK: begin
        if (pend) begin
          take      = 1'b1;
          state_nxt = ST_REPLY;
          reply_nxt = (rx_byte == sum) ? ACK_OK : ACK_ERR;
        end
      end
      ST_REPLY: begin
        if (bus.tx_ready) state_nxt = (reply == ACK_OK) ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (in_frame(state) && tmo) begin
      take      = 1'b0;
      state_nxt = ST_REPLY;
      reply_nxt = ACK_TMO;
    end
  end

  // A new rcv wins over consumption so a byte arriving while the previous one is taken is kept.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend    <= 1'b0;
      rx_byte <= '0;
      n       <= '0;
      idx     <= '0;
      word    <= '0;
      sum     <= '0;
      reply   <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      if (bus.rcv) begin
        pend    <= 1'b1;
        rx_byte <= bus.rxdata;
      end else if (take) begin
        pend <= 1'b0;
      end
      reply <= reply_nxt;
      if (take) begin
        case (state)
          ST_RUN, ST_IDLE: begin
            if (rx_byte == HDR) begin
              sum   <= '0;
              done  <= 1'b0;
              error <= 1'b0;
            end
          end
          ST_LEN_H: begin
            n   <= {rx_byte[AW-9:0], 8'h00};
            sum <= sum_add;
          end
          ST_LEN_L: begin
            n   <= len_val;
            idx <= '0;
            sum <= sum_add;
          end
          ST_DAT_H: begin
            word[DW-1:8] <= rx_byte[DW-9:0];
            sum          <= sum_add;
          end
          ST_DAT_L: begin
            word[7:0] <= rx_byte;
            sum       <= sum_add;
          end
          default: begin
          end
        endcase
      end
      if (state == ST_WRITE) idx <= idx_inc;
      if (state == ST_REPLY && bus.tx_ready) begin
        if (reply == ACK_OK) done <= 1'b1;
        else                 error <= 1'b1;
      end
    end
  end

  assign bus.ram_cs   = (state == ST_WRITE);
  assign bus.ram_rw   = (state != ST_WRITE);
  assign bus.ram_addr = idx;
  assign bus.ram_din  = word;
  assign bus.tx_start = (state == ST_REPLY) && bus.tx_ready;
  assign bus.tx_data  = reply;
  assign cpu_rstn     = (state == ST_RUN);
  assign busy         = (state != ST_RUN) && (state != ST_IDLE);

endmodule

// File: tb/tb_simplez_loader.sv
// Directed bench for simplez_loader: frames are fed byte by byte, a RAM model and a
// uart_tx monitor capture what the loader does, and expected values are hand-computed.
module tb_simplez_loader;

  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rstn;
  logic cpu_rstn;
  logic busy;
  logic done;
  logic error;

  simplez_loader_if #(.AW(9), .DW(12)) bus ();

  simplez_loader #(
    .TIMEOUT (TMO),
    .AUTORUN (1)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .cpu_rstn (cpu_rstn),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [0:511];
  int          writes = 0;
  int          bad_cycles = 0;
  int          tx_count = 0;
  int          tx_base = 0;
  logic [7:0]  last_tx = 8'h00;
  logic        last_tx_cpu = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          w0;
  logic [7:0]  frame [$];

  always @(posedge clk) begin
    if (bus.ram_cs && !bus.ram_rw) begin
      mem[bus.ram_addr] <= bus.ram_din;
      writes <= writes + 1;
    end
    if (bus.ram_cs == bus.ram_rw) bad_cycles <= bad_cycles + 1;
    if (bus.tx_start) begin
      tx_count    <= tx_count + 1;
      last_tx     <= bus.tx_data;
      last_tx_cpu <= cpu_rstn;
    end
  end

  task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Entered and left on a falling edge; rcv is high for exactly one rising edge.
  task send_byte(input logic [7:0] b, input int gap);
    bus.rcv    = 1'b1;
    bus.rxdata = b;
    @(negedge clk);
    bus.rcv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task applyStimulus(input int gap);
    foreach (frame[i]) send_byte(frame[i], gap);
  endtask

  task wait_reply(input string tag, input logic [7:0] exp, input int budget);
    int i;
    i = 0;
    while (tx_count == tx_base && i < budget) begin
      @(negedge clk);
      i++;
    end
    checkOutput({tag, "_seen"}, 32'(tx_count - tx_base), 32'd1);
    checkOutput(tag, 32'(last_tx), 32'(exp));
    tx_base = tx_count;
  endtask

  initial begin
    rstn         = 1'b0;
    bus.rcv      = 1'b0;
    bus.rxdata   = 8'h00;
    bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("rst_cpu_rstn", 32'(cpu_rstn), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_tx_start", 32'(bus.tx_start), 32'd0);
    checkOutput("rst_tx_data", 32'(bus.tx_data), 32'd0);
    checkOutput("rst_ram_cs", 32'(bus.ram_cs), 32'd0);
    checkOutput("rst_ram_rw", 32'(bus.ram_rw), 32'd1);
    checkOutput("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    checkOutput("rst_ram_din", 32'(bus.ram_din), 32'd0);

    rstn = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("autorun_cpu_rstn", 32'(cpu_rstn), 32'd1);
    checkOutput("autorun_no_write", 32'(writes), 32'd0);

    $display("[TB] good frame");
    frame = {8'h41};
    applyStimulus(3);
    checkOutput("run_ignores_byte", 32'(busy), 32'd0);
    checkOutput("run_cpu_still", 32'(cpu_rstn), 32'd1);
    frame = {8'h5A};
    applyStimulus(3);
    checkOutput("hdr_busy", 32'(busy), 32'd1);
    checkOutput("hdr_cpu_held", 32'(cpu_rstn), 32'd0);
    // 00+02+01+23+0A+BC wraps to EC.
    frame = {8'h00, 8'h02, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'hEC};
    applyStimulus(3);
    wait_reply("ack_ok", 8'h4B, 20);
    checkOutput("cpu_held_at_tx", 32'(last_tx_cpu), 32'd0);
    checkOutput("ok_cpu_rstn", 32'(cpu_rstn), 32'd1);
    checkOutput("ok_done", 32'(done), 32'd1);
    checkOutput("ok_error", 32'(error), 32'd0);
    checkOutput("ok_busy", 32'(busy), 32'd0);
    checkOutput("ok_mem0", 32'(mem[0]), 32'h123);
    checkOutput("ok_mem1", 32'(mem[1]), 32'hABC);
    checkOutput("ok_writes", 32'(writes), 32'd2);

    $display("[TB] bad checksum");
    w0 = writes;
    frame = {8'h5A, 8'h00, 8'h02, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'h0B};
    applyStimulus(3);
    wait_reply("chk_err", 8'h45, 20);
    checkOutput("chk_writes", 32'(writes - w0), 32'd2);
    checkOutput("chk_error", 32'(error), 32'd1);
    checkOutput("chk_done", 32'(done), 32'd0);
    checkOutput("chk_cpu_rstn", 32'(cpu_rstn), 32'd0);
    frame = {8'h41};
    applyStimulus(3);
    checkOutput("idle_ignores_byte", 32'(busy), 32'd0);
    checkOutput("idle_cpu_held", 32'(cpu_rstn), 32'd0);

    $display("[TB] length limits");
    w0 = writes;
    frame = {8'h5A, 8'h01, 8'hF9};
    applyStimulus(3);
    wait_reply("len_505", 8'h45, 20);
    frame = {8'h5A, 8'h00, 8'h00};
    applyStimulus(3);
    wait_reply("len_0", 8'h45, 20);
    checkOutput("len_err_flag", 32'(error), 32'd1);
    frame = {8'h5A, 8'h01, 8'hF8};
    applyStimulus(3);
    checkOutput("len_504_busy", 32'(busy), 32'd1);
    checkOutput("len_504_no_reply", 32'(tx_count - tx_base), 32'd0);
    wait_reply("len_504_tmo", 8'h54, TMO + 20);
    checkOutput("len_no_writes", 32'(writes - w0), 32'd0);

    $display("[TB] timeout and recovery");
    frame = {8'h5A, 8'h00, 8'h02, 8'h01};
    applyStimulus(3);
    wait_reply("tmo", 8'h54, TMO + 10);
    checkOutput("tmo_error", 32'(error), 32'd1);
    checkOutput("tmo_cpu_rstn", 32'(cpu_rstn), 32'd0);
    send_byte(8'h5A, 3);
    send_byte(8'h00, TMO - 20);
    checkOutput("gap_under_limit", 32'(tx_count - tx_base), 32'd0);
    // 01+0F+FF wraps to 0F.
    frame = {8'h01, 8'h0F, 8'hFF};
    applyStimulus(3);
    bus.tx_ready = 1'b0;
    send_byte(8'h0F, 10);
    checkOutput("reply_hold", 32'(tx_count - tx_base), 32'd0);
    checkOutput("reply_hold_busy", 32'(busy), 32'd1);
    bus.tx_ready = 1'b1;
    wait_reply("recover_ok", 8'h4B, 20);
    checkOutput("recover_mem0", 32'(mem[0]), 32'hFFF);
    checkOutput("recover_cpu_rstn", 32'(cpu_rstn), 32'd1);

    $display("[TB] reset mid-frame");
    w0 = writes;
    frame = {8'h5A, 8'h00, 8'h02, 8'h07, 8'h77};
    applyStimulus(3);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checkOutput("midrst_cpu_rstn", 32'(cpu_rstn), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_mem0", 32'(mem[0]), 32'h777);
    checkOutput("midrst_writes", 32'(writes - w0), 32'd1);

    // 00+02+01+11+02+22 = 38; the third byte of the payload arrives during WRITE.
    frame = {8'h5A, 8'h00, 8'h02, 8'h01};
    applyStimulus(3);
    send_byte(8'h11, 1);
    checkOutput("write_cycle", 32'(bus.ram_cs), 32'd1);
    frame = {8'h02, 8'h22, 8'h38};
    applyStimulus(3);
    wait_reply("byte_in_write", 8'h4B, 20);
    checkOutput("biw_mem0", 32'(mem[0]), 32'h111);
    checkOutput("biw_mem1", 32'(mem[1]), 32'h222);
    checkOutput("biw_done", 32'(done), 32'd1);

    checkOutput("ram_cs_rw_pairing", 32'(bad_cycles), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
